// File: rtl/upuart_tx_arb.sv
// upuart_tx_arb: round-robin arbiter that shares one upuart_tx between NREQ
// byte-stream requesters. An owner keeps the transmitter until it sends a
// byte flagged last, or until it has been stalled for TMO cycles.
module upuart_tx_arb #(
  parameter int NREQ = 4,
  parameter int TMO  = 1024,
  parameter int TMOW = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  output logic [2:0]        owner,
  output logic              locked
);

  typedef enum logic [1:0] {S_IDLE, S_LOCK, S_SEND, S_GUARD} state_e;

  localparam logic [TMOW-1:0] TMO_W = TMOW'(TMO);

  state_e          state_q;
  logic [2:0]      owner_q;
  logic            locked_q;
  logic [7:0]      tx_data_q;
  logic            tx_wr_q;
  logic [TMOW-1:0] cnt_q;

  // Requester buses widened to the 8-requester maximum so a 3-bit index
  // is always in range regardless of NREQ.
  logic [7:0]  vld8;
  logic [7:0]  last8;
  logic [63:0] data64;

  assign vld8   = 8'(req_valid);
  assign last8  = 8'(req_last);
  assign data64 = 64'(req_data);

  logic [2:0] rr_sel;
  logic       rr_hit;
  logic [3:0] cand;

  // Round-robin search starting just after the current/last owner.
  always_comb begin
    rr_sel = '0;
    rr_hit = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, owner_q} + 4'(k);
      if (cand >= 4'(NREQ)) cand = cand - 4'(NREQ);
      if (!rr_hit && vld8[cand[2:0]]) begin
        rr_hit = 1'b1;
        rr_sel = cand[2:0];
      end
    end
  end

  logic [2:0] sel;
  logic       accept;
  logic [7:0] rdy8;
  logic [7:0] sel_byte;
  logic       sel_last;
  logic       tmo_fire;

  // While locked only the owner is eligible; otherwise rotation decides.
  // In IDLE with no valid requester rr_sel is 0 and vld8[0] is 0, so the
  // accept term below naturally stays low.
  always_comb begin
    sel      = (state_q == S_LOCK) ? owner_q : rr_sel;
    accept   = nrst && ((state_q == S_IDLE) || (state_q == S_LOCK)) &&
               !tx_busy && !hold && vld8[sel];
    rdy8     = accept ? (8'd1 << sel) : 8'd0;
    sel_byte = data64[{sel, 3'b000} +: 8];
    sel_last = last8[sel];
    // Fires on the TMO-th stalled cycle, so the counter never reaches TMO
    // and cannot wrap.
    tmo_fire = (TMO != 0) && (cnt_q == TMO_W - TMOW'(1));
  end

  assign req_ready = rdy8[NREQ-1:0];

  // Arbiter FSM with registered transmitter interface, owner and lock flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      owner_q   <= 3'(NREQ - 1);
      locked_q  <= 1'b0;
      tx_data_q <= 8'h00;
      tx_wr_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            owner_q   <= sel;
            tx_data_q <= sel_byte;
            tx_wr_q   <= 1'b1;
            locked_q  <= ~sel_last;
            cnt_q     <= '0;
            state_q   <= S_SEND;
          end
        end
        S_LOCK: begin
          if (accept) begin
            tx_data_q <= sel_byte;
            tx_wr_q   <= 1'b1;
            locked_q  <= ~sel_last;
            cnt_q     <= '0;
            state_q   <= S_SEND;
          end else if (tmo_fire) begin
            // Owner is kept so the stalled requester ranks last next time.
            locked_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else if (TMO != 0) begin
            cnt_q <= cnt_q + TMOW'(1);
          end
        end
        S_SEND: begin
          tx_wr_q <= 1'b0;
          state_q <= S_GUARD;
        end
        S_GUARD: begin
          // Covers the cycle before upuart_tx reflects the write on tx_busy.
          state_q <= locked_q ? S_LOCK : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign owner   = owner_q;
  assign locked  = locked_q;

endmodule

// File: tb/tb_upuart_tx_arb.sv
// Self-checking bench for upuart_tx_arb: per-requester byte queues drive the
// DUT, a transaction-level model predicts grants, bytes and lock status.
module tb_upuart_tx_arb;
  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic              clk = 1'b0;
  logic              nrst;
  logic [NREQ-1:0]   req_valid, req_last, req_ready;
  logic [8*NREQ-1:0] req_data;
  logic              hold, tx_busy;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic [2:0]        owner;
  logic              locked;

  always #5 clk = ~clk;

  upuart_tx_arb #(.NREQ(NREQ), .TMO(TMO), .TMOW(16)) dut (
    .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .hold(hold),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_wr(tx_wr),
    .owner(owner), .locked(locked)
  );

  int nassert = 0;
  int nfail   = 0;

  // {last, byte} entries per requester
  logic [8:0] q [NREQ][$];
  bit  en [NREQ];
  bit  busy_auto, busy_force;
  int  busy_len, busy_cnt;

  // reference model state
  int         cyc, m_free_at, m_stall;
  logic [2:0] m_owner;
  bit         m_locked, m_wr;
  logic [7:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner   = 3'(NREQ - 1);
    m_locked  = 0;
    m_wr      = 0;
    m_data    = 8'h00;
    m_stall   = 0;
    m_free_at = cyc;
    busy_cnt  = 0;
  endtask

  task automatic push_msg(input int r, input int len);
    for (int b = 0; b < len; b++)
      q[r].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom_range(255))});
  endtask

  // One clock cycle: drive from the queues, check at the falling edge,
  // advance the model, end just after the rising edge.
  task automatic tick();
    bit can, found, acc;
    logic [2:0] s;
    logic [8:0] e;
    logic [NREQ-1:0] exp_rdy;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = en[i] && (q[i].size() > 0);
      e = (q[i].size() > 0) ? q[i][0] : 9'h000;
      req_last[i] = e[8];
      req_data[8*i +: 8] = e[7:0];
    end
    tx_busy = busy_force || (busy_cnt > 0);
    @(negedge clk);
    can   = (cyc >= m_free_at) && !tx_busy && !hold;
    found = 0;
    s     = '0;
    if (m_locked) begin
      if (req_valid[m_owner]) begin found = 1; s = m_owner; end
    end else begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (int'(m_owner) + k) % NREQ;
        if (!found && req_valid[j]) begin found = 1; s = 3'(j); end
      end
    end
    acc     = can && found;
    exp_rdy = acc ? NREQ'(1 << s) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("tx_wr",     32'(tx_wr),     32'(m_wr));
    chk("tx_data",   32'(tx_data),   32'(m_data));
    chk("owner",     32'(owner),     32'(m_owner));
    chk("locked",    32'(locked),    32'(m_locked));
    if (busy_auto && m_wr) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    if (acc) begin
      e         = q[s][0];
      m_owner   = s;
      m_data    = e[7:0];
      m_locked  = !e[8];
      m_free_at = cyc + 3;
      m_stall   = 0;
      void'(q[s].pop_front());
    end else if (m_locked && cyc >= m_free_at) begin
      m_stall++;
      if (m_stall == TMO) begin m_locked = 0; m_stall = 0; end
    end
    m_wr = acc;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"},  32'(req_ready), 32'h0);
    chk({tag, "_tx_wr"},  32'(tx_wr),     32'h0);
    chk({tag, "_data"},   32'(tx_data),   32'h0);
    chk({tag, "_owner"},  32'(owner),     32'(NREQ - 1));
    chk({tag, "_locked"}, 32'(locked),    32'h0);
  endtask

  initial begin
    int left;
    nrst = 0; hold = 0; tx_busy = 0;
    req_valid = '1; req_last = '0; req_data = '0;
    busy_auto = 0; busy_force = 0; busy_len = 20; busy_cnt = 0;
    cyc = 0;
    for (int i = 0; i < NREQ; i++) en[i] = 1;
    #12;
    check_reset_outputs("reset");
    req_valid = '0;
    nrst = 1;
    @(posedge clk); #1;
    model_reset();

    // two single-byte messages at once: 0 then 2, three cycles apart
    q[0].push_back({1'b1, 8'h41});
    q[2].push_back({1'b1, 8'h42});
    repeat (8) tick();

    // "ABC" from requester 1 stays contiguous while 3 waits
    q[1].push_back({1'b0, 8'h41});
    q[1].push_back({1'b0, 8'h42});
    q[1].push_back({1'b1, 8'h43});
    tick();
    q[3].push_back({1'b1, 8'h33});
    repeat (14) tick();

    // transmitter busy for 20 cycles after each write
    busy_auto = 1;
    q[0].push_back({1'b1, 8'hA0});
    q[0].push_back({1'b1, 8'hA1});
    q[1].push_back({1'b1, 8'hB0});
    repeat (75) tick();
    busy_auto = 0;
    while (busy_cnt > 0) tick();

    // hold gates the accept; releasing it accepts in the same cycle
    hold = 1;
    q[2].push_back({1'b1, 8'hC2});
    repeat (4) tick();
    hold = 0;
    repeat (4) tick();

    // stalled owner released by the timeout, then requester 1 granted
    q[0].push_back({1'b0, 8'h55});
    tick();
    q[1].push_back({1'b1, 8'h61});
    repeat (18) tick();

    // reset in the middle of a locked message
    q[3].push_back({1'b0, 8'h77});
    q[3].push_back({1'b0, 8'h78});
    repeat (6) tick();
    chk("pre_reset_locked", 32'(locked), 32'h1);
    #2 nrst = 0;
    #1 check_reset_outputs("midrst");
    for (int i = 0; i < NREQ; i++) q[i].delete();
    @(negedge clk);
    #1 nrst = 1;
    @(posedge clk); #1;
    model_reset();
    q[0].push_back({1'b1, 8'h10});
    q[1].push_back({1'b1, 8'h11});
    repeat (8) tick();

    // random traffic with random hold and busy
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (q[i].size() == 0 && $urandom_range(9) == 0)
          push_msg(i, $urandom_range(1, 3));
      hold       = ($urandom_range(7) == 0);
      busy_force = ($urandom_range(5) == 0);
      tick();
    end
    hold = 0;
    busy_force = 0;

    // drain with a bounded cycle budget
    left = 0;
    for (int n = 0; n < 200; n++) begin
      left = 0;
      for (int i = 0; i < NREQ; i++) left += q[i].size();
      if (left == 0) break;
      tick();
    end
    chk("drain_left", 32'(left), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
